// File: rtl/hazard_stall_controller.sv
// Hazard detection for the 5-stage core: load-use and ecall x17 stalls, mispredict flushes,
// ecall-halt drain sequencing and stall/flush performance counters.
module hazard_stall_controller #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           IF_ID_rs1,
  input  logic [4:0]           IF_ID_rs2,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  input  logic                 is_ecall,
  input  logic                 halt_cond,
  input  logic [4:0]           ID_EX_rd,
  input  logic                 ID_EX_mem_read,
  input  logic                 ID_EX_reg_write,
  input  logic [4:0]           EX_MEM_rd,
  input  logic                 EX_MEM_mem_read,
  input  logic                 mispredict,
  output logic                 pc_write,
  output logic                 IF_ID_write,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_bubble,
  output logic                 is_halted,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int unsigned DcW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e               state_q, state_d;
  logic [DcW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 load_use, ecall_stall, stall;

  always_comb begin
    load_use    = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                  ((use_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                   (use_rs2 && (IF_ID_rs2 == ID_EX_rd)));
    // x17 still in flight: ALU result not yet forwardable, or load data not yet back.
    ecall_stall = is_ecall &&
                  ((ID_EX_reg_write && (ID_EX_rd == 5'd17)) ||
                   (EX_MEM_mem_read && (EX_MEM_rd == 5'd17)));
    stall       = load_use || ecall_stall;
  end

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    case (state_q)
      StRun: begin
        if (mispredict) begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
          flush_cnt_d  = flush_cnt_q + CNT_WIDTH'(1);
        end else if (stall) begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          stall_cnt_d  = stall_cnt_q + CNT_WIDTH'(1);
        end else if (is_ecall && halt_cond) begin
          state_d     = StDrain;
          drain_cnt_d = DcW'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        pc_write     = 1'b0;
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        if (drain_cnt_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_cnt_d = drain_cnt_q - DcW'(1);
        end
      end
      StHalted: begin
        pc_write     = 1'b0;
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end
      default: state_d = StRun;
    endcase
    // A reset cycle lets the front end run freely regardless of state.
    if (reset) begin
      pc_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign is_halted   = (state_q == StHalted);
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Vector bench for hazard_stall_controller: table of per-cycle stimulus with expected
// combinational outputs and post-edge state, run through a scoreboard queue.
module tb_hazard_stall_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    IF_ID_rs1 = '0, IF_ID_rs2 = '0, ID_EX_rd = '0, EX_MEM_rd = '0;
  logic          use_rs1 = 1'b0, use_rs2 = 1'b0, is_ecall = 1'b0, halt_cond = 1'b0;
  logic          ID_EX_mem_read = 1'b0, ID_EX_reg_write = 1'b0, EX_MEM_mem_read = 1'b0;
  logic          mispredict = 1'b0;
  logic          pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, is_halted;
  logic [CW-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.DRAIN_CYCLES(3), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_rs1       (IF_ID_rs1),
    .IF_ID_rs2       (IF_ID_rs2),
    .use_rs1         (use_rs1),
    .use_rs2         (use_rs2),
    .is_ecall        (is_ecall),
    .halt_cond       (halt_cond),
    .ID_EX_rd        (ID_EX_rd),
    .ID_EX_mem_read  (ID_EX_mem_read),
    .ID_EX_reg_write (ID_EX_reg_write),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_mem_read (EX_MEM_mem_read),
    .mispredict      (mispredict),
    .pc_write        (pc_write),
    .IF_ID_write     (IF_ID_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_bubble    (ID_EX_bubble),
    .is_halted       (is_halted),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  typedef struct {
    string         name;
    logic          rst, mis, u1, u2, ec, hc, exmr, exrw, memmr;
    logic [4:0]    rs1, rs2, exrd, memrd;
    logic [3:0]    o;   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble} this cycle
    logic          h;   // is_halted after the edge
    logic [CW-1:0] sc, fc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  function automatic vec_t mkv(string n, int rst, int mis, int rs1, int rs2, int u1, int u2,
                               int ec, int hc, int exrd, int exmr, int exrw, int memrd,
                               int memmr, int o, int h, int sc, int fc);
    vec_t v;
    v.name = n;     v.rst = 1'(rst);     v.mis = 1'(mis);
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);    v.u1 = 1'(u1);   v.u2 = 1'(u2);
    v.ec = 1'(ec);  v.hc = 1'(hc);       v.exrd = 5'(exrd);
    v.exmr = 1'(exmr); v.exrw = 1'(exrw); v.memrd = 5'(memrd); v.memmr = 1'(memmr);
    v.o = 4'(o);    v.h = 1'(h);         v.sc = CW'(sc); v.fc = CW'(fc);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    logic [3:0] got_o;
    @(negedge clk);
    reset = v.rst;  mispredict = v.mis; IF_ID_rs1 = v.rs1; IF_ID_rs2 = v.rs2;
    use_rs1 = v.u1; use_rs2 = v.u2;     is_ecall = v.ec;   halt_cond = v.hc;
    ID_EX_rd = v.exrd; ID_EX_mem_read = v.exmr; ID_EX_reg_write = v.exrw;
    EX_MEM_rd = v.memrd; EX_MEM_mem_read = v.memmr;
    sb_q.push_back(v);
    #2;
    e = sb_q.pop_front();
    got_o = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble};
    checks++;
    if (got_o !== e.o) begin
      errors++;
      $display("FAIL %s outputs pc/ifw/flush/bubble got %b want %b", e.name, got_o, e.o);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({is_halted, stall_count, flush_count} !== {e.h, e.sc, e.fc}) begin
      errors++;
      $display("FAIL %s state halted/stall/flush got %b/%0d/%0d want %b/%0d/%0d",
               e.name, is_halted, stall_count, flush_count, e.h, e.sc, e.fc);
    end
  endtask

  initial begin
    //                 name           rst mis rs1 rs2 u1 u2 ec hc exrd exmr exrw memrd memmr o   h sc fc
    tbl.push_back(mkv("reset",          1, 0,  0,  0, 0, 0, 0, 0,  0,  0,   0,   0,   0, 'b1100, 0, 0, 0));
    tbl.push_back(mkv("reset_ovr",      1, 1,  5,  0, 1, 0, 0, 0,  5,  1,   0,   0,   0, 'b1100, 0, 0, 0));
    tbl.push_back(mkv("lu_rs1",         0, 0,  5,  0, 1, 0, 0, 0,  5,  1,   0,   0,   0, 'b0001, 0, 1, 0));
    tbl.push_back(mkv("lu_rd0",         0, 0,  0,  0, 1, 0, 0, 0,  0,  1,   0,   0,   0, 'b1100, 0, 1, 0));
    tbl.push_back(mkv("lu_rs2_unused",  0, 0,  0,  7, 0, 0, 0, 0,  7,  1,   0,   0,   0, 'b1100, 0, 1, 0));
    tbl.push_back(mkv("lu_rs2",         0, 0,  0,  7, 0, 1, 0, 0,  7,  1,   0,   0,   0, 'b0001, 0, 2, 0));
    tbl.push_back(mkv("ec_ex_rw17",     0, 0,  0,  0, 0, 0, 1, 1, 17,  0,   1,   0,   0, 'b0001, 0, 3, 0));
    tbl.push_back(mkv("ec_mem_ld17",    0, 0,  0,  0, 0, 0, 1, 1,  0,  0,   0,  17,   1, 'b0001, 0, 4, 0));
    tbl.push_back(mkv("ec_ex_ld17",     0, 0, 17,  0, 1, 0, 1, 1, 17,  1,   1,   0,   0, 'b0001, 0, 5, 0));
    tbl.push_back(mkv("ec_nohalt",      0, 0,  0,  0, 0, 0, 1, 0,  0,  0,   0,   0,   0, 'b1100, 0, 5, 0));
    tbl.push_back(mkv("mis_prio",       0, 1,  5,  0, 1, 0, 1, 1,  5,  1,   0,   0,   0, 'b1111, 0, 5, 1));
    tbl.push_back(mkv("mis",            0, 1,  0,  0, 0, 0, 0, 0,  0,  0,   0,   0,   0, 'b1111, 0, 5, 2));
    tbl.push_back(mkv("run",            0, 0,  0,  0, 0, 0, 0, 0,  0,  0,   0,   0,   0, 'b1100, 0, 5, 2));
    tbl.push_back(mkv("ec_halt",        0, 0,  0,  0, 0, 0, 1, 1,  0,  0,   0,   0,   0, 'b1100, 0, 5, 2));
    tbl.push_back(mkv("drain1",         0, 1,  5,  0, 1, 0, 1, 1,  5,  1,   0,   0,   0, 'b0111, 0, 5, 2));
    tbl.push_back(mkv("drain2",         0, 1,  5,  0, 1, 0, 1, 1,  5,  1,   0,   0,   0, 'b0111, 0, 5, 2));
    tbl.push_back(mkv("drain3",         0, 0,  0,  0, 0, 0, 0, 0,  0,  0,   0,   0,   0, 'b0111, 1, 5, 2));
    foreach (tbl[i]) apply(tbl[i]);

    // Halted is sticky whatever the inputs do.
    for (int i = 0; i < 10; i++) begin
      apply(mkv("halt_hold", 0, $urandom_range(1), $urandom_range(31), $urandom_range(31),
                $urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                $urandom_range(31), $urandom_range(1), $urandom_range(1), $urandom_range(31),
                $urandom_range(1), 'b0111, 1, 5, 2));
    end

    // Reset in the middle of a drain, then a full drain again.
    apply(mkv("r_reset",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b1100, 0, 0, 0));
    apply(mkv("r_lu",     0, 0, 9, 0, 1, 0, 0, 0, 9, 1, 0, 0, 0, 'b0001, 0, 1, 0));
    apply(mkv("r_mis",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b1111, 0, 1, 1));
    apply(mkv("r_ecall",  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 'b1100, 0, 1, 1));
    apply(mkv("r_drain1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0111, 0, 1, 1));
    apply(mkv("r_drain2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b1100, 0, 0, 0));
    apply(mkv("r_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b1100, 0, 0, 0));
    apply(mkv("r2_ecall", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 'b1100, 0, 0, 0));
    apply(mkv("r2_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0111, 0, 0, 0));
    apply(mkv("r2_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0111, 0, 0, 0));
    apply(mkv("r2_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0111, 1, 0, 0));
    apply(mkv("r2_halt",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b0111, 1, 0, 0));

    // 17 load-use cycles on a 4-bit counter wrap to 1.
    apply(mkv("w_reset",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'b1100, 0, 0, 0));
    for (int i = 0; i < 17; i++) begin
      apply(mkv("wrap_lu", 0, 0, 3, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 'b0001, 0, (i + 1) % 16, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Hazard-side companion to the pipeline's data forwarding logic in the 5-stage RISC-V core.
- Detects hazards that forwarding cannot cover: load-use, and the ecall x17 source not yet produced. Drives PC/IF_ID write enables, bubbles and flushes.
- Sequences ecall-halt pipeline drain through a small FSM and sticky is_halted.
- Keeps stall and flush performance counters.

Parameters:
- DRAIN_CYCLES, 3: cycles spent in DRAIN after the halting ecall leaves ID, so older instructions retire through WB.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- IF_ID_rs1  input  5  rs1 index of the instruction in ID
- IF_ID_rs2  input  5  rs2 index of the instruction in ID
- use_rs1  input  1  ID instruction reads rs1
- use_rs2  input  1  ID instruction reads rs2
- is_ecall  input  1  ID instruction is ecall
- halt_cond  input  1  forwarded x17 == 10; valid only when no ecall stall is raised
- ID_EX_rd  input  5  destination of the instruction in EX
- ID_EX_mem_read  input  1  EX instruction is a load
- ID_EX_reg_write  input  1  EX instruction writes rd
- EX_MEM_rd  input  5  destination of the instruction in MEM
- EX_MEM_mem_read  input  1  MEM instruction is a load
- mispredict  input  1  branch/jump resolved in EX disagrees with prediction
- pc_write  output  1  PC register update enable
- IF_ID_write  output  1  IF_ID latch enable
- IF_ID_flush  output  1  IF_ID becomes a NOP
- ID_EX_bubble  output  1  ID_EX control signals zeroed
- is_halted  output  1  core halted (sticky)
- stall_count  output  CNT_WIDTH  cycles with a load-use or ecall stall
- flush_count  output  CNT_WIDTH  cycles with a mispredict flush

Behaviour:
- FSM states: RUN, DRAIN, HALTED. All state and counters are updated on posedge clk.
- On reset: state=RUN, drain counter=0, is_halted=0, stall_count=0, flush_count=0.
- Outputs are combinational from state and inputs. During a reset cycle the outputs are pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0.
- Signals evaluated in RUN:
  - load_use = ID_EX_mem_read & ID_EX_rd!=0 & ((use_rs1 & IF_ID_rs1==ID_EX_rd) | (use_rs2 & IF_ID_rs2==ID_EX_rd)).
  - ecall_stall = is_ecall & ((ID_EX_reg_write & ID_EX_rd==17) | (EX_MEM_mem_read & EX_MEM_rd==17)).
  - stall = load_use | ecall_stall.
- RUN priority, highest first:
  1. mispredict: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1; flush_count+1. The stall and ecall in ID are wrong-path and ignored.
  2. stall: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0; stall_count+1.
  3. is_ecall & halt_cond: outputs as normal this cycle, so the ecall advances. Next state is DRAIN with drain counter=DRAIN_CYCLES-1.
  4. Otherwise: pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0.
- DRAIN: pc_write=0, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1.
  - Counter decrements each cycle; at 0 the next state is HALTED.
  - mispredict, stall and is_ecall are ignored; no counter updates.
- HALTED: same outputs as DRAIN, is_halted=1. State holds until reset.
- Boundary conditions:
  - rd=0 never causes a load-use stall.
  - A load in MEM with rd=17 stalls an ecall. A load in EX with rd=17 stalls via both terms; it counts as one stall cycle.
  - Counters wrap modulo 2^CNT_WIDTH.
  - reset asserted in any state, including mid-DRAIN, returns to RUN the next cycle.
  - Non-halting ecall (halt_cond=0) with no stall behaves as a normal instruction.

Test Plan:
- Load-use: ID_EX_mem_read=1, ID_EX_rd=5; ID rs1=5, use_rs1=1 for one cycle -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1; stall_count 0->1. Same stimulus with ID_EX_rd=0 -> no stall.
- Ecall x17 hazard: is_ecall=1, ID_EX_reg_write=1, ID_EX_rd=17 -> stall. Next cycle EX_MEM_mem_read=1, EX_MEM_rd=17 -> stall again; stall_count=2. Then no hazard with halt_cond=1 -> enters DRAIN.
- Halt drain: from RUN, is_ecall=1, halt_cond=1 -> exactly 3 cycles with pc_write=0 and is_halted=0, then is_halted=1. It stays 1 for 10 more cycles regardless of inputs.
- Mispredict priority: mispredict=1 together with load_use=1 and is_ecall&halt_cond=1 -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1. flush_count+1, stall_count unchanged, state stays RUN.
- Reset mid-DRAIN: reset asserted on the 2nd DRAIN cycle -> next cycle is_halted=0, pc_write=1, counters=0; a later halting ecall drains the full 3 cycles again.
- Counter wrap (CNT_WIDTH=4): 17 consecutive load-use cycles -> stall_count reads 1.
